// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU sequencer: opcodes, ALU A-operand selects,
// FSM state encoding and the decoded-instruction bundle.
package cpu_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOVI_A = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOVI_B = 4'b0111;
  localparam logic [3:0] OP_HLT    = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JZ     = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_IN   = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [1:0] a_sel;
    logic [3:0] b_val;
    logic       ld_a;
    logic       ld_b;
    logic       ld_out;
    logic       is_add;
    logic       is_jmp;
    logic       is_jz;
    logic       is_hlt;
  } dec_t;

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Sequencer-side bundle: instruction-memory req/ack fetch port plus ALU/register controls.
// master = sequencer, slave = memory/datapath side.
interface cpu_seq_ctrl_if;
  logic [3:0] imem_addr;
  logic       imem_req;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [1:0] alu_a_sel;
  logic [3:0] alu_b_val;
  logic       zf;
  logic       ld_a;
  logic       ld_b;
  logic       ld_out;
  logic       halted;

  modport master (
    output imem_addr, imem_req, alu_a_sel, alu_b_val, ld_a, ld_b, ld_out, halted,
    input  imem_ack, imem_data, zf
  );

  modport slave (
    input  imem_addr, imem_req, alu_a_sel, alu_b_val, ld_a, ld_b, ld_out, halted,
    output imem_ack, imem_data, zf
  );
endinterface

// File: rtl/cpu_decode.sv
// Combinational instruction decode: IR -> operand selects, load strobes, control class.
// Zero latency; unlisted opcodes decode as NOP (operands idle, no strobes).
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  output dec_t       dec
);

  logic [3:0] op;
  logic [3:0] im;

  assign op = ir[7:4];
  assign im = ir[3:0];

  always_comb begin
    dec = '0;
    dec.a_sel = SEL_ZERO;
    case (op)
      OP_ADD_A:  begin dec.a_sel = SEL_A;  dec.b_val = im; dec.ld_a = 1'b1; dec.is_add = 1'b1; end
      OP_ADD_B:  begin dec.a_sel = SEL_B;  dec.b_val = im; dec.ld_b = 1'b1; dec.is_add = 1'b1; end
      OP_MOVI_A: begin dec.b_val = im; dec.ld_a = 1'b1; end
      OP_MOVI_B: begin dec.b_val = im; dec.ld_b = 1'b1; end
      OP_MOV_AB: begin dec.a_sel = SEL_B;  dec.ld_a = 1'b1; end
      OP_MOV_BA: begin dec.a_sel = SEL_A;  dec.ld_b = 1'b1; end
      OP_IN_A:   begin dec.a_sel = SEL_IN; dec.ld_a = 1'b1; end
      OP_IN_B:   begin dec.a_sel = SEL_IN; dec.ld_b = 1'b1; end
      OP_OUT_B:  begin dec.a_sel = SEL_B;  dec.ld_out = 1'b1; end
      OP_OUT_I:  begin dec.b_val = im; dec.ld_out = 1'b1; end
      OP_JMP:    dec.is_jmp = 1'b1;
      OP_JZ:     dec.is_jz  = 1'b1;
      OP_HLT:    dec.is_hlt = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Fetch/execute sequencer: FETCH (held until imem_ack) -> EXEC -> WB, 3 cycles per
// instruction with zero-wait memory; each cycle without ack stretches FETCH by one.
module cpu_seq_ctrl
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  cpu_seq_ctrl_if.master bus
);

  state_t     state_q, state_d;
  logic [3:0] pc_q;
  logic [7:0] ir_q;
  logic       flag_q;
  dec_t       dec;

  cpu_decode u_decode (
    .ir  (ir_q),
    .dec (dec)
  );

  always_comb begin
    state_d       = state_q;
    bus.imem_req  = 1'b0;
    bus.alu_a_sel = SEL_ZERO;
    bus.alu_b_val = 4'd0;
    bus.ld_a      = 1'b0;
    bus.ld_b      = 1'b0;
    bus.ld_out    = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        bus.alu_a_sel = dec.a_sel;
        bus.alu_b_val = dec.b_val;
        bus.ld_a      = dec.ld_a;
        bus.ld_b      = dec.ld_b;
        bus.ld_out    = dec.ld_out;
        state_d       = ST_WB;
      end
      ST_WB:    state_d = dec.is_hlt ? ST_HALT : ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.imem_addr = pc_q;
  assign bus.halted    = (state_q == ST_HALT);

  // zf in WB reflects the EXEC sum, so flag and PC both commit on the WB->FETCH edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= 4'd0;
      ir_q    <= 8'd0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH && bus.imem_ack) ir_q <= bus.imem_data;
      if (state_q == ST_WB && !dec.is_hlt) begin
        if (dec.is_add) flag_q <= bus.zf;
        if (dec.is_jmp)                pc_q <= ir_q[3:0];
        else if (dec.is_jz && flag_q)  pc_q <= ir_q[3:0];
        else                           pc_q <= pc_q + 4'd1;
      end
    end
  end

endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle fetch/execute sequencer for the 4-bit CPU. It fetches 8-bit instructions from instruction memory over a req/ack handshake and drives the ALU operand selects, immediate value and register load strobes. It samples the ALU's registered zero flag into its own flag for conditional jumps and owns the 4-bit program counter. It sits between instruction memory and the ALU/register-file datapath; the ALU and the A/B/OUT registers stay outside this block.

## Interface
Parameters:
- none (all widths fixed: 4-bit data/address, 8-bit instruction)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset; **one clock; reset is asynchronous and active-high**
- imem_addr  output  4  fetch address (= PC)
- imem_req  output  1  fetch request, high only in FETCH
- imem_ack  input  1  instruction valid on imem_data this cycle
- imem_data  input  8  instruction: [7:4] opcode, [3:0] immediate
- alu_a_sel  output  2  ALU A-operand mux: 0 reg A, 1 reg B, 2 input port, 3 constant 0
- alu_b_val  output  4  ALU B operand (immediate or 0)
- zf  input  1  ALU zero flag (ALU-internal DFF, updates every clock)
- ld_a, ld_b, ld_out  output  1 each  register load strobes (ALU sum → register)
- halted  output  1  high in HALT

## Operation
- States: IDLE → FETCH → EXEC → WB → FETCH …; HALT is terminal until rst.
- IDLE: one cycle after reset release, then FETCH.
- FETCH: imem_req=1, imem_addr=PC. On imem_ack=1, latch imem_data into IR and go to EXEC. Otherwise stay in FETCH, with PC and request held.
- EXEC: one cycle. Decode IR and drive alu_a_sel, alu_b_val and at most one ld_* strobe.
- WB: flag/PC update, then FETCH (or HALT).
- Opcodes (A/B/OUT = destination; sum = a_sel + b_val):
  - 0000 ADD A,Im: sel A, b=Im, ld_a, updates flag
  - 0101 ADD B,Im: sel B, b=Im, ld_b, updates flag
  - 0011 MOV A,Im: sel 0, b=Im, ld_a
  - 0111 MOV B,Im: sel 0, b=Im, ld_b
  - 0001 MOV A,B: sel B, b=0, ld_a
  - 0100 MOV B,A: sel A, b=0, ld_b
  - 0010 IN A: sel IN, b=0, ld_a
  - 0110 IN B: sel IN, b=0, ld_b
  - 1001 OUT B: sel B, b=0, ld_out
  - 1011 OUT Im: sel 0, b=Im, ld_out
  - 1111 JMP Im
  - 1110 JZ Im
  - 1000 HLT
  - all others NOP (no strobes, PC+1)
- Flag: the ALU's ZF DFF captures the EXEC sum at the EXEC→WB edge. The controller copies zf into flag_q at the WB→FETCH edge, for ADD opcodes only; every other opcode preserves flag_q.
- PC (updated at WB→FETCH edge):
  - JMP: PC←Im
  - JZ: PC←Im if flag_q=1, else PC+1
  - all others: PC+1, modulo 16 (15→0 wraps, no flag effect)
- HLT: WB → HALT. halted=1, no req, no strobes, PC frozen.

## Timing
- Reset values (async, immediate): state=IDLE, PC=0, IR=0, flag_q=0. Consequently imem_req=0, imem_addr=0, all ld_*=0, alu_a_sel=3, alu_b_val=0, halted=0.
- Zero-wait memory (ack in the same cycle as req): 3 cycles per instruction (FETCH, EXEC, WB). Each cycle of ack delay adds one FETCH cycle.
- ld_* are single-cycle pulses in EXEC only. The datapath registers capture at the EXEC→WB edge.
- Operand outputs are only meaningful in EXEC. In every other state: alu_a_sel=3, alu_b_val=0.
- JZ reads flag_q, i.e. the result of the most recent ADD, regardless of intervening non-ADD instructions.
- rst mid-operation (any state, including a pending FETCH): all state clears immediately, any in-flight fetch is abandoned, and the next fetch starts from address 0.
- imem_ack outside FETCH is ignored.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams
  - a_sel encodings (SEL_A, SEL_B, SEL_IN, SEL_ZERO)
  - state encoding typedef
- One combinational sub-module, cpu_decode: maps IR → {a_sel, b_val, ld_a, ld_b, ld_out, is_add, is_jmp, is_jz, is_hlt}.
- The top contains the FSM, PC, IR and flag_q.

## Test plan
- Reset then program MOV A,3; ADD A,4 with zero-wait memory → ld_a pulses in cycles 3 and 6 after IDLE, with b_val=3 then 4 and sel 3 then 0. PC = 2 after 7 cycles.
- ADD A,0 with datapath A=0 (zf=1 in WB), then JZ 9 → PC=9. Repeat with zf=0 in WB → PC=2.
- ADD sets flag=1, then MOV B,5, then JZ 12 → jump taken (MOV preserves flag).
- ack delayed 4 cycles on address 5 → imem_req stays high for 5 cycles with addr 5, no strobes, and the instruction takes 7 cycles.
- PC=15 executing NOP → next imem_addr=0. JMP 15 followed by HLT at 15 → halted=1 and imem_req stays 0 for 20 cycles.
- rst asserted mid-FETCH and mid-EXEC → outputs drop to reset values in the same cycle, and the first post-reset fetch is at address 0.
